// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader.
//   SYNC_BYTE      first byte of every program frame
//   load_state_e   loader FSM states
//   rx_state_e     UART receiver bit-timing states
//   clks_per_bit() integer clock cycles per UART bit
package uart_program_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } load_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver.
//   i_clk, i_rst    system clock, asynchronous active-high reset
//   i_rx            serial line, idle high, asynchronous to i_clk
//   o_byte_valid    one-cycle pulse after a stop bit sampled high
//   o_byte_data     received byte, held until the next valid byte
//   o_frame_err     one-cycle pulse when the stop bit is sampled low
// Byte interface: valid-only, no backpressure. o_byte_data is meaningful only
// in the cycle o_byte_valid is high; the consumer must take it then.
module uart_rx_core
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);

  logic [1:0]       r_sync;
  logic             r_rx_prev;
  rx_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             w_rx;

  assign w_rx = r_sync[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // Synchronizer resets to the idle line level so release is not a start edge.
      r_sync       <= 2'b11;
      r_rx_prev    <= 1'b1;
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      o_byte_valid <= 1'b0;
      o_byte_data  <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], i_rx};
      r_rx_prev    <= w_rx;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          // Edge rather than level, so a line stuck low after a framing
          // error does not retrigger until it has returned high.
          if (r_rx_prev && !w_rx) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == CNT_W'(HALF_BIT - 1)) begin
            r_cnt   <= '0;
            // Line back high at mid start bit: treat as a glitch.
            r_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (w_rx) begin
              o_byte_valid <= 1'b1;
              o_byte_data  <= r_shift;
            end else begin
              o_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Receives a program image over UART and writes it into instruction RAM,
// holding the CPU in reset until a checksum-verified image is in place.
// Frame: A5, LEN_LO, LEN_HI, N little-endian 32-bit words, XOR of data bytes.
//   i_clk, i_rst   system clock, asynchronous active-high reset
//   i_rx           UART serial input (8N1, idle high)
//   o_imem_we      one-cycle instruction RAM write strobe
//   o_imem_addr    word-aligned byte address of the write (held between strobes)
//   o_imem_wdata   write data (held between strobes)
//   o_cpu_hold     1 = keep the CPU in reset
//   o_load_done    one-cycle pulse after a good image
//   o_load_err     sticky error flag, cleared by the next sync byte
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_load_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int MAX_WORDS    = (2 ** ADDR_W) / 4;
  localparam int TMO_W        = $clog2(TIMEOUT_CYC + 1);

  logic              w_byte_valid;
  logic [7:0]        w_byte_data;
  logic              w_frame_err;
  logic [15:0]       w_len;
  logic              w_in_frame;
  logic              w_timeout;
  logic              w_abort;

  load_state_e       r_state;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_words_left;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_word_sr;
  logic [7:0]        r_chk;
  logic [ADDR_W-1:0] r_addr;
  logic [TMO_W-1:0]  r_tmo;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx         (i_rx),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte_data),
    .o_frame_err  (w_frame_err)
  );

  assign w_len      = {w_byte_data, r_len_lo};
  assign w_in_frame = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                      (r_state == ST_DATA)   || (r_state == ST_CHK);
  assign w_timeout  = (r_tmo == TMO_W'(TIMEOUT_CYC));
  assign w_abort    = w_in_frame && (w_frame_err || w_timeout);

  // Inter-byte idle counter: only runs inside a frame, saturates at the limit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo <= '0;
    end else if (!w_in_frame || w_byte_valid) begin
      r_tmo <= '0;
    end else if (!w_timeout) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_len_lo     <= '0;
      r_words_left <= '0;
      r_byte_idx   <= '0;
      r_word_sr    <= '0;
      r_chk        <= '0;
      r_addr       <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_cpu_hold   <= 1'b0;
      o_load_done  <= 1'b0;
      o_load_err   <= 1'b0;
    end else begin
      o_imem_we   <= 1'b0;
      o_load_done <= 1'b0;
      if (w_abort) begin
        // cpu_hold is left high so a partial image never runs.
        r_state    <= ST_ERR;
        o_load_err <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_byte_valid && w_byte_data == SYNC_BYTE) begin
              r_state    <= ST_LEN_LO;
              o_cpu_hold <= 1'b1;
              o_load_err <= 1'b0;
              r_addr     <= '0;
              r_chk      <= '0;
              r_byte_idx <= '0;
            end
          end
          ST_LEN_LO: begin
            if (w_byte_valid) begin
              r_len_lo <= w_byte_data;
              r_state  <= ST_LEN_HI;
            end
          end
          ST_LEN_HI: begin
            if (w_byte_valid) begin
              if (32'(w_len) > MAX_WORDS) begin
                r_state    <= ST_ERR;
                o_load_err <= 1'b1;
              end else if (w_len == 16'd0) begin
                r_state <= ST_CHK;
              end else begin
                r_words_left <= w_len;
                r_state      <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (w_byte_valid) begin
              r_chk      <= r_chk ^ w_byte_data;
              r_byte_idx <= r_byte_idx + 1'b1;
              // Bytes enter at the top so the first byte ends up least significant.
              r_word_sr  <= {w_byte_data, r_word_sr[23:8]};
              if (r_byte_idx == 2'd3) begin
                o_imem_we    <= 1'b1;
                o_imem_wdata <= {w_byte_data, r_word_sr};
                o_imem_addr  <= r_addr;
                r_addr       <= r_addr + ADDR_W'(4);
                r_words_left <= r_words_left - 1'b1;
                if (r_words_left == 16'd1) r_state <= ST_CHK;
              end
            end
          end
          ST_CHK: begin
            if (w_byte_valid) begin
              if (w_byte_data == r_chk) begin
                r_state     <= ST_DONE;
                o_load_done <= 1'b1;
                o_cpu_hold  <= 1'b0;
              end else begin
                r_state    <= ST_ERR;
                o_load_err <= 1'b1;
              end
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          ST_ERR:  r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD      = 100_000;
  localparam int CPB       = 16;
  localparam int ADDR_W    = 12;
  localparam int TMO       = 2000;
  localparam int MAX_WORDS = 1024;
  localparam int W         = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx  = 1'b1;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  uart_program_loader #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx         (rx),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_cpu_hold   (cpu_hold),
    .o_load_done  (load_done),
    .o_load_err   (load_err)
  );

  // Capture writes and done pulses away from the active edge.
  always @(negedge clk) begin
    if (imem_we) obs_q.push_back({imem_addr, imem_wdata});
    if (load_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
    if (!stop_bit) idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] fb[$], input int gap_max);
    foreach (fb[i]) begin
      send_byte(fb[i], 1'b1);
      idle($urandom_range(0, gap_max));
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: decode the byte list and list the words it must write.
  task automatic model_frame(input logic [7:0] fb[$], output bit ok);
    int n;
    logic [7:0] chk;
    logic [31:0] d;
    n  = int'({fb[2], fb[1]});
    ok = 1'b0;
    if (n > MAX_WORDS) return;
    chk = 8'h00;
    for (int w = 0; w < n; w++) begin
      d = {fb[6+4*w], fb[5+4*w], fb[4+4*w], fb[3+4*w]};
      chk = chk ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
      exp_q.push_back({ADDR_W'(4 * w), d});
    end
    ok = (fb.size() == 4 + 4 * n) && (fb[3+4*n] == chk);
  endtask

  task automatic build_frame(input int n, input bit good, output logic [7:0] fb[$]);
    logic [7:0] chk;
    logic [7:0] b;
    logic [15:0] len;
    len = 16'(n);
    fb  = {};
    fb.push_back(8'hA5);
    fb.push_back(len[7:0]);
    fb.push_back(len[15:8]);
    chk = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = ($urandom_range(0, 4) == 0) ? 8'hA5 : 8'($urandom);
      fb.push_back(b);
      chk ^= b;
    end
    fb.push_back(good ? chk : chk ^ 8'($urandom_range(1, 255)));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] o;
    int d0;
    rst = 1'b1;
    idle(3);
    checks++;
    if ({imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b addr=%h data=%h hold=%b done=%b err=%b exp all 0",
               imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err);
    end
    rst = 1'b0;
    idle(5);
    send_byte(8'hA5, 1'b1);
    checks++;
    if (cpu_hold !== 1'b1) begin
      errors++; $display("FAIL reset_sync_hold got %b exp 1", cpu_hold);
    end
    send_byte(8'h01, 1'b1);
    // Start a byte and pull reset in the middle of it, off the clock edge.
    rx = 1'b0;
    idle(CPB * 3);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err} !== '0) begin
      errors++;
      $display("FAIL reset_midbyte got hold=%b err=%b done=%b we=%b exp all 0",
               cpu_hold, load_err, load_done, imem_we);
    end
    rx = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(CPB * 12);
    d0 = done_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(20);
    checks++;
    if (cpu_hold !== 1'b0 || load_err !== 1'b0 || done_cnt != d0) begin
      errors++;
      $display("FAIL idle_ignore got hold=%b err=%b done=%0d exp 0 0 0",
               cpu_hold, load_err, done_cnt - d0);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL idle_writes got %0d exp 0", obs_q.size());
    end
    while (obs_q.size() > 0) o = obs_q.pop_front();
  endtask

  task automatic test_known();
    logic [7:0] fb[$];
    logic [W-1:0] o, e;
    int d0;
    fb = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'hB3, 8'h05, 8'h00, 8'h00, 8'hA5};
    exp_q.push_back({12'h000, 32'h0000_0013});
    exp_q.push_back({12'h004, 32'h0000_05B3});
    d0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    checks++;
    if (cpu_hold !== 1'b1 || load_err !== 1'b0) begin
      errors++; $display("FAIL known_sync got hold=%b err=%b exp 1 0", cpu_hold, load_err);
    end
    send_frame(fb, 3);
    idle(20);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL known_nwrites got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL known_write got %h exp %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    checks++;
    if (done_cnt - d0 != 1 || cpu_hold !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL known_done got done=%0d hold=%b err=%b exp 1 0 0", done_cnt - d0, cpu_hold, load_err);
    end
  endtask

  task automatic test_bad_chk();
    logic [7:0] fb[$];
    logic [W-1:0] o, e;
    int d0;
    bit ok;
    fb = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'hB3, 8'h05, 8'h00, 8'h00, 8'h00};
    model_frame(fb, ok);
    d0 = done_cnt;
    send_frame(fb, 3);
    idle(20);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL badchk_nwrites got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL badchk_write got %h exp %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    checks++;
    if (load_err !== !ok || cpu_hold !== 1'b1 || done_cnt != d0) begin
      errors++;
      $display("FAIL badchk_flags got err=%b hold=%b done=%0d exp 1 1 0", load_err, cpu_hold, done_cnt - d0);
    end
    // The next sync byte must clear the sticky flag.
    send_byte(8'hA5, 1'b1);
    checks++;
    if (load_err !== 1'b0) begin
      errors++; $display("FAIL badchk_clear got %b exp 0", load_err);
    end
  endtask

  task automatic test_oversize();
    int d0;
    d0 = done_cnt;
    rst = 1'b1; idle(2); rst = 1'b0; idle(4);
    send_frame('{8'hA5, 8'h01, 8'h04}, 2);
    send_frame('{8'h11, 8'h22, 8'h33, 8'h44}, 2);
    idle(20);
    checks++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || done_cnt != d0) begin
      errors++;
      $display("FAIL oversize_flags got err=%b hold=%b done=%0d exp 1 1 0", load_err, cpu_hold, done_cnt - d0);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL oversize_writes got %0d exp 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_framing();
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h13}, 2);
    checks++;
    if (load_err !== 1'b0) begin
      errors++; $display("FAIL framing_pre got err=%b exp 0", load_err);
    end
    send_byte(8'h00, 1'b0);
    idle(20);
    checks++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL framing_err got err=%b hold=%b writes=%0d exp 1 1 0", load_err, cpu_hold, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_timeout();
    // N = 1024 is the largest image that fits; it must be accepted.
    send_frame('{8'hA5, 8'h00, 8'h04}, 0);
    idle(1800);
    checks++;
    if (load_err !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL timeout_early got err=%b hold=%b exp 0 1", load_err, cpu_hold);
    end
    idle(400);
    checks++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_err got err=%b hold=%b writes=%0d exp 1 1 0", load_err, cpu_hold, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_empty_glitch();
    int d0;
    d0 = done_cnt;
    send_frame('{8'hA5, 8'h00}, 2);
    // Short low pulse: shorter than half a bit, must not become a byte.
    rx = 1'b0; idle(4); rx = 1'b1; idle(CPB * 3);
    send_frame('{8'h00, 8'h00}, 2);
    idle(20);
    checks++;
    if (done_cnt - d0 != 1 || load_err !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL empty_done got done=%0d err=%b hold=%b exp 1 0 0", done_cnt - d0, load_err, cpu_hold);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL empty_writes got %0d exp 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] fa[$], fb2[$], all[$];
    logic [W-1:0] o, e;
    bit ok_a, ok_b;
    int d0;
    build_frame(2, 1'b1, fa);
    build_frame(3, 1'b1, fb2);
    model_frame(fa, ok_a);
    model_frame(fb2, ok_b);
    all = {fa, fb2};
    d0 = done_cnt;
    send_frame(all, 0);
    idle(20);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_nwrites got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_write got %h exp %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    checks++;
    if (done_cnt - d0 != int'(ok_a) + int'(ok_b) || load_err !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done got done=%0d err=%b hold=%b exp 2 0 0", done_cnt - d0, load_err, cpu_hold);
    end
  endtask

  task automatic test_random();
    logic [7:0] fb[$];
    logic [W-1:0] o, e;
    bit ok;
    int d0;
    for (int f = 0; f < 5; f++) begin
      build_frame($urandom_range(0, 4), ($urandom_range(0, 2) != 0), fb);
      model_frame(fb, ok);
      d0 = done_cnt;
      send_frame(fb, 30);
      idle(20);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_nwrites got %0d exp %0d", f, obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL rand%0d_write got %h exp %h", f, o, e); end
      end
      obs_q.delete(); exp_q.delete();
      checks++;
      if (done_cnt - d0 != int'(ok) || load_err !== !ok || cpu_hold !== !ok) begin
        errors++;
        $display("FAIL rand%0d_flags got done=%0d err=%b hold=%b exp %0d %b %b",
                 f, done_cnt - d0, load_err, cpu_hold, int'(ok), !ok, !ok);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_known();
    test_bad_chk();
    idle(CPB * 40);
    test_oversize();
    test_framing();
    test_timeout();
    test_empty_glitch();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
